fp_add_pipe: RTL and testbench
==============================

Name: fp_add_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor; successor to the team's combinational single-precision adder.
- Adds over the combinational adder: add/sub mode, round-to-nearest-even with guard/round/sticky, full special-value handling, exception flags and a 4-stage valid/ready pipeline with backpressure.
- Feeds the FP datapath of the processor; default widths give binary32.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit implied).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; transfer when in_valid&&in_ready.
- a  in  1+EXP_W+MAN_W  operand A {sign,exp,frac}.
- b  in  1+EXP_W+MAN_W  operand B.
- op_sub  in  1  0: a+b, 1: a-b (sign of b inverted).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready.
- result  out  1+EXP_W+MAN_W  packed sum.
- flags  out  4  {invalid, overflow, underflow, inexact}, bits 3..0.

Behaviour:
- Reset (rst_n=0 at edge): all stage valid bits 0, out_valid=0, result=0, flags=0. Mid-operation reset discards in-flight ops; nothing emitted afterwards.
- Stages: S1 unpack/classify/swap so |L|>=|S| (compare exp, then frac). S2 align: shift S right by expL-expS, saturated at MAN_W+3; shifted-out bits OR into sticky. S3 add/sub magnitudes (sub when signs differ after op_sub). S4 normalise via leading-zero count, round RNE, pack, set flags.
- Advance enable: adv = !out_valid || out_ready; every stage moves together when adv=1, holds when 0. in_ready = adv (combinational).
- Latency 4: op accepted at edge k appears with out_valid=1 after edge k+4 when unstalled. Throughput 1/cycle. Results in order; none dropped or duplicated.
- While out_valid&&!out_ready: result/flags stable.
- Denormal inputs (exp=0) are treated as zero of same sign.
- Exact cancellation -> +0; (-0)+(-0) -> -0.
- Rounding: RNE on guard, round, sticky; mantissa carry-out after rounding increments exponent. inexact = any of G/R/S set (or over/underflow).
- Overflow (biased exp >= 2^EXP_W-1 after round): ±inf, overflow=1, inexact=1.
- Underflow (biased exp <= 0 after normalise): signed zero, underflow=1, inexact=1.
- NaN input or inf-inf: canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0). invalid=1 for inf-inf or signalling NaN input (frac MSB 0, frac!=0); quiet NaN input gives invalid=0.
- inf + finite -> that inf, flags 0.
- Flags for normal results cleared per op; flags belong to the result they accompany.

Decomposition:
- Package fp_pkg: width/bias functions of EXP_W/MAN_W, canonical qNaN builder, flag bit index constants, operand class enum {ZERO, NORMAL, INF, QNAN, SNAN}.
- One sub-module: fp_lzc, parametrised leading-zero counter used in S4.

Test Plan:
- a=0x3F800000, b=0x40000000, op_sub=0 -> result 0x40400000, flags 0, out_valid 4 cycles after acceptance.
- a=0x3F800000, b=0x3F800000, op_sub=1 -> 0x00000000, flags 0.
- a=b=0x7F7FFFFF, add -> 0x7F800000, flags overflow+inexact (0b0101).
- a=0x7F800000, b=0xFF800000, add -> 0x7FC00000, flags invalid (0b1000).
- RNE ties: 0x3F800000+0x33800000 -> 0x3F800000; 0x3F800001+0x33800000 -> 0x3F800002; both inexact (0b0001).
- Backpressure: stream 6 ops back-to-back, hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 while stalled, result stable, all 6 results in order with no loss; assert rst_n=0 for one cycle mid-stream -> out_valid=0 next cycle, no stale results.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder:
// format helpers, flag bit positions and the operand classification enum.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits: sign 0, exp all ones, frac MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    // NOTE: default first so every path assigns count and no latch is inferred.
    count = CNT_W'(WIDTH);
    // NOTE: blocking assignments here, so the highest set bit, visited last, wins.
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754-style adder/subtractor: operand capture, then classify/swap,
// align, add, and normalise/round/pack stages sharing one valid/ready advance enable.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W     = fp_width(EXP_W, MAN_W);
  localparam int SIG_W = MAN_W + 4;             // hidden, fraction, guard, round, sticky
  localparam int SUM_W = SIG_W + 1;             // plus carry-out
  localparam int LZ_W  = $clog2(SUM_W + 1);
  localparam int XE_W  = EXP_W + 2;             // signed headroom for exponent arithmetic
  localparam logic [63:0]      QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [XE_W-1:0]  EXP_MAX   = XE_W'(2 * fp_bias(EXP_W) + 1);
  localparam logic [EXP_W-1:0] SH_MAX    = EXP_W'(SIG_W - 1);

  function automatic fp_class_e classify(input logic [W-2:0] mag);
    if (mag[W-2:MAN_W] == '0) return CLS_ZERO;
    if (mag[W-2:MAN_W] != '1) return CLS_NORMAL;
    if (mag[MAN_W-1:0] == '0) return CLS_INF;
    return mag[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic           in_vld, s1_valid, s2_valid, s3_valid;
  logic [W-1:0]   in_a, in_b;
  logic           in_sub;
  logic [W-1:0]   res_c;
  logic [3:0]     flg_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_vld    <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      in_vld    <= in_valid;
      s1_valid  <= in_vld;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      result    <= res_c;
      flags     <= flg_c;
    end
  end

  // ---------------- S1: classify, resolve specials, order by magnitude
  fp_class_e    cls_a, cls_b;
  logic         sgn_a, sgn_b, a_ge_b, c1_spec;
  logic [W-2:0] mag_a, mag_b;
  logic [W-1:0] c1_spec_res;
  logic [3:0]   c1_spec_flg;

  always_comb begin
    cls_a       = classify(in_a[W-2:0]);
    cls_b       = classify(in_b[W-2:0]);
    sgn_a       = in_a[W-1];
    sgn_b       = in_b[W-1] ^ in_sub;
    mag_a       = (cls_a == CLS_ZERO) ? '0 : in_a[W-2:0];  // denormals flush to zero
    mag_b       = (cls_b == CLS_ZERO) ? '0 : in_b[W-2:0];
    a_ge_b      = mag_a >= mag_b;
    c1_spec     = 1'b1;
    c1_spec_res = QNAN;
    c1_spec_flg = '0;
    if (cls_a inside {CLS_QNAN, CLS_SNAN} || cls_b inside {CLS_QNAN, CLS_SNAN})
      c1_spec_flg[FLAG_INVALID] = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    else if (cls_a == CLS_INF && cls_b == CLS_INF && sgn_a != sgn_b)
      c1_spec_flg[FLAG_INVALID] = 1'b1;
    else if (cls_a == CLS_INF)
      c1_spec_res = {sgn_a, in_a[W-2:0]};
    else if (cls_b == CLS_INF)
      c1_spec_res = {sgn_b, in_b[W-2:0]};
    else
      c1_spec = 1'b0;
  end

  logic         s1_sign_l, s1_eff_sub, s1_spec;
  logic [W-2:0] s1_mag_l, s1_mag_s;
  logic [W-1:0] s1_spec_res;
  logic [3:0]   s1_spec_flg;

  // ---------------- S2: align the smaller significand, collecting sticky
  logic [EXP_W-1:0]   exp_l, exp_s, exp_diff, shamt;
  logic [SIG_W-1:0]   sig_l, sig_s, sig_s_al;
  logic [2*SIG_W-1:0] wide;

  always_comb begin
    exp_l    = s1_mag_l[W-2:MAN_W];
    exp_s    = s1_mag_s[W-2:MAN_W];
    exp_diff = exp_l - exp_s;
    shamt    = (exp_diff > SH_MAX) ? SH_MAX : exp_diff;
    sig_l    = {|exp_l, s1_mag_l[MAN_W-1:0], 3'b000};
    sig_s    = {|exp_s, s1_mag_s[MAN_W-1:0], 3'b000};
    wide     = {sig_s, {SIG_W{1'b0}}} >> shamt;
    sig_s_al = {wide[2*SIG_W-1:SIG_W+1], wide[SIG_W] | (|wide[SIG_W-1:0])};
  end

  logic [SIG_W-1:0] s2_sig_l, s2_sig_s;
  logic [EXP_W-1:0] s2_exp_l, s3_exp_l;
  logic             s2_sign_l, s2_eff_sub, s2_spec, s3_sign_l, s3_eff_sub, s3_spec;
  logic [W-1:0]     s2_spec_res, s3_spec_res;
  logic [3:0]       s2_spec_flg, s3_spec_flg;
  logic [SUM_W-1:0] s3_sum;

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (adv) begin
      in_a        <= a;
      in_b        <= b;
      in_sub      <= op_sub;
      s1_sign_l   <= a_ge_b ? sgn_a : sgn_b;
      s1_eff_sub  <= sgn_a ^ sgn_b;
      s1_mag_l    <= a_ge_b ? mag_a : mag_b;
      s1_mag_s    <= a_ge_b ? mag_b : mag_a;
      s1_spec     <= c1_spec;
      s1_spec_res <= c1_spec_res;
      s1_spec_flg <= c1_spec_flg;
      s2_sig_l    <= sig_l;
      s2_sig_s    <= sig_s_al;
      s2_exp_l    <= exp_l;
      s2_sign_l   <= s1_sign_l;
      s2_eff_sub  <= s1_eff_sub;
      s2_spec     <= s1_spec;
      s2_spec_res <= s1_spec_res;
      s2_spec_flg <= s1_spec_flg;
      s3_sum      <= s2_eff_sub ? ({1'b0, s2_sig_l} - {1'b0, s2_sig_s})
                                : ({1'b0, s2_sig_l} + {1'b0, s2_sig_s});
      s3_exp_l    <= s2_exp_l;
      s3_sign_l   <= s2_sign_l;
      s3_eff_sub  <= s2_eff_sub;
      s3_spec     <= s2_spec;
      s3_spec_res <= s2_spec_res;
      s3_spec_flg <= s2_spec_flg;
    end
  end

  // ---------------- S4: normalise, round to nearest even, pack, flag
  logic [LZ_W-1:0]  lz;
  logic [SUM_W-1:0] norm;
  logic [XE_W-1:0]  exp_pre, exp_fin;
  logic [MAN_W-1:0] frac_n;
  logic [MAN_W:0]   mant_r;
  logic             grd, rnd, stk, rnd_up;

  fp_lzc #(.WIDTH(SUM_W)) u_lzc (.din(s3_sum), .count(lz));

  always_comb begin
    norm    = s3_sum << lz;
    frac_n  = norm[SUM_W-2:4];
    grd     = norm[3];
    rnd     = norm[2];
    stk     = |norm[1:0];
    rnd_up  = grd && (rnd || stk || frac_n[0]);
    mant_r  = {1'b0, frac_n} + (MAN_W+1)'(rnd_up);
    exp_pre = {2'b00, s3_exp_l} + XE_W'(1) - XE_W'(lz);
    exp_fin = exp_pre + XE_W'(mant_r[MAN_W]);
    res_c   = {s3_sign_l, exp_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
    flg_c   = '0;
    flg_c[FLAG_INEXACT] = grd || rnd || stk;
    if (s3_spec) begin
      res_c = s3_spec_res;
      flg_c = s3_spec_flg;
    end else if (!norm[SUM_W-1]) begin
      // Exact zero: cancellation gives +0, only a true sum of -0s keeps the sign.
      res_c = {s3_sign_l && !s3_eff_sub, {(W-1){1'b0}}};
      flg_c = '0;
    end else if (exp_pre[XE_W-1] || exp_pre == '0) begin
      res_c = {s3_sign_l, {(W-1){1'b0}}};
      flg_c = '0;
      flg_c[FLAG_UNDERFLOW] = 1'b1;
      flg_c[FLAG_INEXACT]   = 1'b1;
    end else if (exp_fin >= EXP_MAX) begin
      res_c = {s3_sign_l, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_c = '0;
      flg_c[FLAG_OVERFLOW] = 1'b1;
      flg_c[FLAG_INEXACT]  = 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: directed binary32 vectors with hand-computed
// results, latency, backpressure and mid-stream reset.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc_cyc;
    bit          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   n_id    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Monitor: a transfer happens at the next rising edge when this negedge sees valid&&ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
      end else begin
        e = sb.pop_front();
        check($sformatf("result[%0d]", e.id), result, e.res);
        check($sformatf("flags[%0d]", e.id), {28'd0, flags}, {28'd0, e.flg});
        if (e.lat) check($sformatf("latency[%0d]", e.id), cyc - e.acc_cyc, 4);
      end
    end
  end

  // Entered and left at posedge+1; in_valid stays high so calls chain back-to-back.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                      input logic [31:0] er, input logic [3:0] ef, input bit lat);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    op_sub   = vs;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{res: er, flg: ef, acc_cyc: cyc + 1, lat: lat, id: n_id});
        n_id++;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_result", result, 0);
    check("reset_flags", {28'd0, flags}, 0);
    rst_n = 1'b1;

    // Isolated op into an empty pipe: latency measured too.
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    idle(8);

    // Directed vectors, issued back-to-back.
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1'b0); // exact cancel
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b0); // overflow
    send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 1'b0); // inf-inf
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1'b0); // inf-inf via sub
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b0); // tie, even stays
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1'b0); // tie, odd rounds up
    send(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001, 1'b0); // tie at 2^24
    send(32'h4B800000, 32'h3F800001, 1'b0, 32'h4B800001, 4'b0001, 1'b0); // above half via sticky
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1'b0); // inf + finite
    send(32'hFF800000, 32'hC0000000, 1'b0, 32'hFF800000, 4'b0000, 1'b0); // -inf + finite
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b0); // quiet NaN
    send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1'b0); // signalling NaN
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b0); // -0 + -0
    send(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, 1'b0); // underflow
    send(32'h40000000, 32'hBF800000, 1'b1, 32'h40400000, 4'b0000, 1'b0); // 2 - (-1)
    send(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, 1'b0); // 1 - 2^-24 exact
    send(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0000, 1'b0); // denormal as zero
    drain();

    // Backpressure: six back-to-back ops, consumer stalls three cycles once output appears.
    fork
      begin
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1'b0);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
        send(32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 4'b0000, 1'b0);
        send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 4'b0000, 1'b0);
        in_valid = 1'b0;
      end
      begin
        bit          seen;
        logic [31:0] held_res;
        logic [3:0]  held_flg;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) seen = 1'b1;
        end
        check("stall_out_valid_rise", {31'd0, seen}, 1);
        out_ready = 1'b0;
        held_res  = result;
        held_flg  = flags;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          #1;
          check($sformatf("stall_in_ready[%0d]", i), {31'd0, in_ready}, 0);
          check($sformatf("stall_out_valid[%0d]", i), {31'd0, out_valid}, 1);
          check($sformatf("stall_result[%0d]", i), result, held_res);
          check($sformatf("stall_flags[%0d]", i), {28'd0, flags}, {28'd0, held_flg});
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-stream reset: everything in flight is discarded.
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("midreset_out_valid", {31'd0, out_valid}, 0);
    check("midreset_result", result, 0);
    check("midreset_flags", {28'd0, flags}, 0);
    rst_n = 1'b1;
    idle(8);
    check("post_reset_idle_out_valid", {31'd0, out_valid}, 0);

    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
